// File: rtl/bitwise_logic_pipe.sv
// Pipelined multi-op bitwise logic unit with valid/ready flow control and collapsing bubbles.
// Optional completed-result counter on perf_count when LOGIC_PIPE_PERF_EN is defined.
module bitwise_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_PIPE_PERF_EN
    output logic [31:0]      perf_count,
`endif
    output logic             out_zero
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer must hold its payload stable while valid is high and ready is low.

    logic [WIDTH-1:0]              res_d;
    logic                          res_zero_d;
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0]             v_q;
    logic [STAGES-1:0][WIDTH-1:0]  data_q;
    logic [STAGES-1:0]             zero_q;
    logic [STAGES:0]               chain_v;
    logic [STAGES:0][WIDTH-1:0]    chain_d;
    logic [STAGES:0]               chain_z;

    always_comb begin
        res_d = '0;
        unique case (op)
            3'b000:  res_d = ~a;
            3'b001:  res_d = a & b;
            3'b010:  res_d = a | b;
            3'b011:  res_d = a ^ b;
            3'b100:  res_d = ~(a | b);
            3'b101:  res_d = ~(a & b);
            3'b110:  res_d = ~(a ^ b);
            default: res_d = a;
        endcase
        res_zero_d = (res_d == '0);
    end

    // Entry k of each chain is what stage k loads from: the input for k = 0,
    // stage k-1 otherwise.
    assign chain_v = {v_q, in_valid};
    assign chain_d = {data_q, res_d};
    assign chain_z = {zero_q, res_zero_d};

    // Stage k may load when any stage from k to the end is empty (bubbles
    // collapse) or the last stage is emptying this cycle.
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v_q[j]) adv[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            data_q <= '0;
            zero_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= chain_v[k];
                    if (chain_v[k]) begin
                        data_q[k] <= chain_d[k];
                        zero_q[k] <= chain_z[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_zero  = zero_q[STAGES-1];

`ifdef LOGIC_PIPE_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    assign perf_d = perf_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (out_valid && out_ready) begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: drivers push expected results, a monitor pops and compares.
// Exercises perf_count as well when LOGIC_PIPE_PERF_EN is defined.
module tb_bitwise_logic_pipe;

    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
`ifdef LOGIC_PIPE_PERF_EN
    logic [31:0]   perf_count;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_xfer = 0;
    bit rand_bp = 1'b0;
    logic [W:0] exp_q[$];

    bitwise_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef LOGIC_PIPE_PERF_EN
        .perf_count(perf_count),
`endif
        .out_zero  (out_zero)
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the op table.
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~(x | y);
            3'd5:    return ~(x & y);
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    // driver tasks: called just after a rising edge, return just after the accepting edge
    task automatic send_exp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] e);
        int t;
        op = o; a = x; b = y; in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({(e == '0), e});
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 60) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        send_exp(o, x, y, ref_op(o, x, y));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); t++;
        end
        #1;
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // monitor / scoreboard
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic          prev_zero;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_zero", out_zero, prev_zero);
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_data);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("out_zero", out_zero, e[W]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_zero  = out_zero;
        end
    end

    logic [W-1:0] sweep_exp [8];
    logic [2:0]   bp_op [6];
    logic [W-1:0] bp_a [6];
    logic [W-1:0] bp_b [6];

    initial begin
        int lat, c0, acc;
        sweep_exp = '{32'h0F8F00A0, 32'h0000005F, 32'hFF7FFFFF, 32'hFF7FFFA0,
                      32'h00800000, 32'hFFFFFFA0, 32'h0080005F, 32'hF070FF5F};
        rst = 1'b1; in_valid = 1'b1; op = 3'd7; a = 32'h1234_5678; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // single op latency
        send_exp(3'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); lat++;
        end
        check("latency", lat, S);
        @(posedge clk); #1;
        drain();

        // op sweep, back to back
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_exp(3'(i), 32'hF070FF5F, 32'h0F0F00FF, sweep_exp[i]);
        in_valid = 1'b0;
        check("sweep_cycles", cyc - c0, 8);
        drain();

        // zero flag
        send_exp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        in_valid = 1'b0;
        drain();

        // backpressure: fill the pipe with the consumer stalled
        for (int i = 0; i < 6; i++) begin
            bp_op[i] = 3'($urandom_range(0, 7));
            bp_a[i] = $urandom; bp_b[i] = $urandom;
        end
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            op = bp_op[acc]; a = bp_a[acc]; b = bp_b[acc]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({(ref_op(bp_op[acc], bp_a[acc], bp_b[acc]) == '0),
                                 ref_op(bp_op[acc], bp_a[acc], bp_b[acc])});
                acc++;
            end
            @(posedge clk); #1;
        end
        op = bp_op[acc]; a = bp_a[acc]; b = bp_b[acc];
        @(negedge clk);
        check("bp_accepts", acc, S);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_held_data", out_data, ref_op(bp_op[0], bp_a[0], bp_b[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_accept_ready", in_ready, 1);
        if (in_ready) begin
            exp_q.push_back({(ref_op(bp_op[acc], bp_a[acc], bp_b[acc]) == '0),
                             ref_op(bp_op[acc], bp_a[acc], bp_b[acc])});
            acc++;
        end
        @(posedge clk); #1;
        for (int i = acc; i < 6; i++) send(bp_op[i], bp_a[i], bp_b[i]);
        in_valid = 1'b0;
        drain();

        // reset with two results in flight
        out_ready = 1'b0;
        send(3'd1, $urandom, $urandom);
        send(3'd2, $urandom, $urandom);
        op = 3'd7; a = 32'hDEADBEEF; in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        n_xfer = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // randomized traffic with random backpressure and input gaps
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 5) == 0) ? a : $urandom);
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

`ifdef LOGIC_PIPE_PERF_EN
        check("perf_count_total", perf_count, 32'(n_xfer));
        force dut.perf_q = 32'hFFFFFFFE;
        @(posedge clk); #1;
        release dut.perf_q;
        for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom);
        in_valid = 1'b0;
        drain();
        check("perf_count_wrap", perf_count, 32'h00000001);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
